// File: rtl/weight_bram_sequencer_pkg.sv
// Shared sizes and FSM encoding for the weight BRAM sequencer.
// Imported by the sequencer top and its address counter.
package weight_bram_sequencer_pkg;

  localparam int DEPTH_DEF = 28;
  localparam int AW_DEF    = 5;
  localparam int DW_DEF    = 16;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOAD   = 2'd1,
    ST_FETCH  = 2'd2,
    ST_FINISH = 2'd3
  } state_e;

endpackage

// File: rtl/weight_addr_counter.sv
// BRAM address counter: clear, increment, saturate at DEPTH.
// One extra bit so DEPTH itself is representable.
module weight_addr_counter
  import weight_bram_sequencer_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF,
  parameter int CW    = AW_DEF + 1
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          clr_i,
  input  logic          inc_i,
  output logic [CW-1:0] cnt_o,
  output logic          term_o
);

  localparam logic [CW-1:0] TERM = CW'(DEPTH);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)
      cnt_d = '0;
    else if (inc_i && cnt_q != TERM)
      cnt_d = cnt_q + CW'(1);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign cnt_o  = cnt_q;
  assign term_o = (cnt_q == TERM);

endmodule

// File: rtl/weight_bram_sequencer.sv
// Loads host weights into one neuron BRAM and streams them
// back to the MAC as an indexed valid/ready beat sequence.
module weight_bram_sequencer
  import weight_bram_sequencer_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF,
  parameter int AW    = AW_DEF,
  parameter int DW    = DW_DEF
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          START,
  input  logic          MODE,
  input  logic          ABORT,
  input  logic          LD_VALID,
  input  logic [DW-1:0] LD_DATA,
  output logic          LD_READY,
  output logic [AW-1:0] BRAM_ADDR,
  output logic [DW-1:0] BRAM_DI,
  output logic          BRAM_EN,
  output logic          BRAM_WE,
  input  logic [DW-1:0] BRAM_DO,
  output logic          W_VALID,
  input  logic          W_READY,
  output logic [DW-1:0] W_DATA,
  output logic [AW-1:0] W_INDEX,
  output logic          W_LAST,
  output logic          BUSY,
  output logic          DONE
);

  localparam int            CW    = AW + 1;
  localparam logic [CW-1:0] LASTA = CW'(DEPTH - 1);

  state_e        state_q;
  logic          w_valid_q;
  logic [DW-1:0] w_data_q;
  logic [AW-1:0] w_index_q;
  logic          w_last_q;
  logic          done_q;

  logic [CW-1:0] cnt;
  logic          term;
  logic          in_load, in_fetch;
  logic          ld_acc, issue;

  assign in_load  = (state_q == ST_LOAD);
  assign in_fetch = (state_q == ST_FETCH);
  assign ld_acc   = in_load && LD_VALID && !term;
  // One-entry output register: refill only when empty or draining.
  assign issue    = in_fetch && (!w_valid_q || W_READY) && !term;

  weight_addr_counter #(
    .DEPTH (DEPTH),
    .CW    (CW)
  ) u_cnt (
    .clk_i  (CLK),
    .rst_i  (RST),
    .clr_i  ((state_q == ST_IDLE) || ABORT),
    .inc_i  (ld_acc || issue),
    .cnt_o  (cnt),
    .term_o (term)
  );

  assign LD_READY  = in_load && !term;
  assign BRAM_EN   = ld_acc || issue;
  assign BRAM_WE   = ld_acc;
  assign BRAM_DI   = in_load ? LD_DATA : '0;
  assign BRAM_ADDR = ((in_load || in_fetch) && !term)
                   ? cnt[AW-1:0] : '0;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q   <= ST_IDLE;
      w_valid_q <= 1'b0;
      w_data_q  <= '0;
      w_index_q <= '0;
      w_last_q  <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      // BRAM_DO settles on the falling edge after the issue.
      if (issue) begin
        w_valid_q <= 1'b1;
        w_data_q  <= BRAM_DO;
        w_index_q <= cnt[AW-1:0];
        w_last_q  <= (cnt == LASTA);
      end else if (W_READY) begin
        w_valid_q <= 1'b0;
      end
      if (ABORT) begin
        state_q   <= ST_IDLE;
        w_valid_q <= 1'b0;
      end else begin
        unique case (state_q)
          ST_IDLE:
            if (START)
              state_q <= MODE ? ST_LOAD : ST_FETCH;
          ST_LOAD:
            if (ld_acc && cnt == LASTA) begin
              state_q <= ST_FINISH;
              done_q  <= 1'b1;
            end
          ST_FETCH:
            if (w_valid_q && W_READY && w_last_q) begin
              state_q <= ST_FINISH;
              done_q  <= 1'b1;
            end
          ST_FINISH:
            state_q <= ST_IDLE;
        endcase
      end
    end
  end

  assign W_VALID = w_valid_q;
  assign W_DATA  = w_data_q;
  assign W_INDEX = w_index_q;
  assign W_LAST  = w_last_q;
  assign DONE    = done_q;
  assign BUSY    = (state_q != ST_IDLE);

endmodule

// File: tb/tb_weight_bram_sequencer.sv
// Bench for weight_bram_sequencer: BRAM model, stream scoreboard
// and directed load/fetch/stall/abort/reset vectors.
module tb_weight_bram_sequencer;

  localparam int DEPTH = 28;
  localparam int AW    = 5;
  localparam int DW    = 16;

  logic          CLK = 1'b0;
  logic          RST = 1'b1;
  logic          START = 1'b0;
  logic          MODE = 1'b0;
  logic          ABORT = 1'b0;
  logic          LD_VALID = 1'b0;
  logic [DW-1:0] LD_DATA = '0;
  logic          LD_READY;
  logic [AW-1:0] BRAM_ADDR;
  logic [DW-1:0] BRAM_DI;
  logic          BRAM_EN;
  logic          BRAM_WE;
  logic [DW-1:0] BRAM_DO = '0;
  logic          W_VALID;
  logic          W_READY = 1'b0;
  logic [DW-1:0] W_DATA;
  logic [AW-1:0] W_INDEX;
  logic          W_LAST;
  logic          BUSY;
  logic          DONE;

  weight_bram_sequencer dut (
    .CLK       (CLK),
    .RST       (RST),
    .START     (START),
    .MODE      (MODE),
    .ABORT     (ABORT),
    .LD_VALID  (LD_VALID),
    .LD_DATA   (LD_DATA),
    .LD_READY  (LD_READY),
    .BRAM_ADDR (BRAM_ADDR),
    .BRAM_DI   (BRAM_DI),
    .BRAM_EN   (BRAM_EN),
    .BRAM_WE   (BRAM_WE),
    .BRAM_DO   (BRAM_DO),
    .W_VALID   (W_VALID),
    .W_READY   (W_READY),
    .W_DATA    (W_DATA),
    .W_INDEX   (W_INDEX),
    .W_LAST    (W_LAST),
    .BUSY      (BUSY),
    .DONE      (DONE)
  );

  always #5 CLK = ~CLK;

  // BRAM: acts on the falling edge, DO held while EN=0
  logic [DW-1:0] mem [32];
  always @(negedge CLK) begin
    if (BRAM_EN) begin
      if (BRAM_WE) mem[BRAM_ADDR] <= BRAM_DI;
      else         BRAM_DO <= mem[BRAM_ADDR];
    end
  end

  int n_pass = 0;
  int n_total = 0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s actual=%h required=%h t=%0t",
                  name, act, exp, $time);
  endtask

  // Scoreboard: loads write 0x0100+n to addr n in order; fetches
  // deliver index 0..DEPTH-1 exactly once with the loaded data.
  int   exp_wr = 0;
  int   exp_idx = 0;
  logic done_pend = 1'b0;
  always @(negedge CLK) begin
    logic nd;
    nd = 1'b0;
    if (RST) begin
      done_pend = 1'b0;
    end else begin
      chk("done_pulse", 32'(DONE), 32'(done_pend));
      if (START && !BUSY && !ABORT) begin
        if (MODE) exp_wr = 0;
        else      exp_idx = 0;
      end
      if (BRAM_EN && BRAM_WE) begin
        chk("wr_addr", 32'(BRAM_ADDR), 32'(exp_wr));
        chk("wr_data", 32'(BRAM_DI), 32'h100 + 32'(exp_wr));
        exp_wr++;
        if (exp_wr == DEPTH && !ABORT) nd = 1'b1;
      end
      if (W_VALID) begin
        chk("beat_idx", 32'(W_INDEX), 32'(exp_idx));
        chk("beat_data", 32'(W_DATA), 32'h100 + 32'(exp_idx));
        chk("beat_last", 32'(W_LAST), 32'(exp_idx == DEPTH - 1));
        if (W_READY && !ABORT) begin
          if (exp_idx == DEPTH - 1) nd = 1'b1;
          exp_idx++;
        end
      end
      if (W_VALID && !W_READY)
        chk("stall_no_read", 32'(BRAM_EN), 32'd0);
      if (BRAM_EN)
        chk("addr_range", 32'(BRAM_ADDR < AW'(DEPTH)), 32'd1);
      done_pend = nd;
    end
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  logic          r_vld [40];
  logic [DW-1:0] r_dat [40];
  logic [AW-1:0] r_idx [40];
  logic          r_lst [40];
  logic          r_don [40];
  logic          r_en  [40];
  logic          r_bsy [40];

  // Cycle 0 carries START; snapshots taken mid-cycle.
  task automatic fetch_run(input int ncyc, input int st_lo,
                           input int st_hi, input int ab_c);
    W_READY = 1'b1;
    START = 1'b1;
    MODE = 1'b0;
    tick();
    START = 1'b0;
    for (int c = 1; c <= ncyc; c++) begin
      W_READY = !(c >= st_lo && c <= st_hi);
      ABORT = (c == ab_c);
      @(negedge CLK);
      r_vld[c] = W_VALID;
      r_dat[c] = W_DATA;
      r_idx[c] = W_INDEX;
      r_lst[c] = W_LAST;
      r_don[c] = DONE;
      r_en[c]  = BRAM_EN;
      r_bsy[c] = BUSY;
      tick();
    end
    ABORT = 1'b0;
    W_READY = 1'b1;
  endtask

  initial begin
    tick();
    tick();
    @(negedge CLK);
    chk("rst_valid", 32'(W_VALID), 32'd0);
    chk("rst_busy", 32'(BUSY), 32'd0);
    chk("rst_done", 32'(DONE), 32'd0);
    chk("rst_en", 32'(BRAM_EN), 32'd0);
    chk("rst_ldrdy", 32'(LD_READY), 32'd0);
    tick();
    RST = 1'b0;
    tick();

    // LOAD with one idle gap and a START while busy
    START = 1'b1;
    MODE = 1'b1;
    tick();
    START = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (i == 10) begin
        LD_VALID = 1'b0;
        tick();
      end
      LD_VALID = 1'b1;
      LD_DATA = 16'h0100 + 16'(i);
      if (i == 5) begin
        START = 1'b1;
        MODE = 1'b0;
      end
      if (i == 0) begin
        @(negedge CLK);
        chk("ld_ready_on", 32'(LD_READY), 32'd1);
        chk("ld_we", 32'(BRAM_WE), 32'd1);
      end
      tick();
      START = 1'b0;
      MODE = 1'b1;
    end
    LD_VALID = 1'b0;
    @(negedge CLK);
    chk("ld_done", 32'(DONE), 32'd1);
    chk("ld_ready_off", 32'(LD_READY), 32'd0);
    tick();
    @(negedge CLK);
    chk("ld_idle", 32'(BUSY), 32'd0);
    tick();

    // FETCH at full throughput
    fetch_run(31, 99, 99, -1);
    chk("f_c1_vld", 32'(r_vld[1]), 32'd0);
    chk("f_c2_vld", 32'(r_vld[2]), 32'd1);
    chk("f_c2_dat", 32'(r_dat[2]), 32'h0100);
    chk("f_c2_idx", 32'(r_idx[2]), 32'd0);
    chk("f_c15_idx", 32'(r_idx[15]), 32'd13);
    chk("f_c28_lst", 32'(r_lst[28]), 32'd0);
    chk("f_c29_dat", 32'(r_dat[29]), 32'h011B);
    chk("f_c29_lst", 32'(r_lst[29]), 32'd1);
    chk("f_c29_done", 32'(r_don[29]), 32'd0);
    chk("f_c30_done", 32'(r_don[30]), 32'd1);
    chk("f_c30_vld", 32'(r_vld[30]), 32'd0);
    chk("f_c31_busy", 32'(r_bsy[31]), 32'd0);
    tick();

    // Backpressure while index 5 is presented
    fetch_run(34, 7, 9, -1);
    for (int c = 7; c <= 9; c++) begin
      chk("bp_dat", 32'(r_dat[c]), 32'h0105);
      chk("bp_idx", 32'(r_idx[c]), 32'd5);
      chk("bp_en", 32'(r_en[c]), 32'd0);
    end
    chk("bp_c10_idx", 32'(r_idx[10]), 32'd5);
    chk("bp_c11_idx", 32'(r_idx[11]), 32'd6);
    chk("bp_c32_dat", 32'(r_dat[32]), 32'h011B);
    chk("bp_c33_done", 32'(r_don[33]), 32'd1);
    tick();

    // ABORT while index 10 is presented, then restart
    fetch_run(14, 99, 99, 12);
    chk("ab_c12_idx", 32'(r_idx[12]), 32'd10);
    chk("ab_c13_busy", 32'(r_bsy[13]), 32'd0);
    chk("ab_c13_vld", 32'(r_vld[13]), 32'd0);
    chk("ab_c13_done", 32'(r_don[13]), 32'd0);
    fetch_run(31, 99, 99, -1);
    chk("rs_c2_vld", 32'(r_vld[2]), 32'd1);
    chk("rs_c2_idx", 32'(r_idx[2]), 32'd0);
    chk("rs_c30_done", 32'(r_don[30]), 32'd1);
    tick();

    // ABORT with START in IDLE stays idle
    START = 1'b1;
    ABORT = 1'b1;
    tick();
    START = 1'b0;
    ABORT = 1'b0;
    @(negedge CLK);
    chk("ab_start_busy", 32'(BUSY), 32'd0);
    tick();

    // Reset in the middle of a load
    START = 1'b1;
    MODE = 1'b1;
    tick();
    START = 1'b0;
    for (int i = 0; i < 5; i++) begin
      LD_VALID = 1'b1;
      LD_DATA = 16'h0100 + 16'(i);
      tick();
    end
    RST = 1'b1;
    #1;
    chk("mrst_busy", 32'(BUSY), 32'd0);
    chk("mrst_en", 32'(BRAM_EN), 32'd0);
    chk("mrst_we", 32'(BRAM_WE), 32'd0);
    chk("mrst_ldrdy", 32'(LD_READY), 32'd0);
    chk("mrst_vld", 32'(W_VALID), 32'd0);
    chk("mrst_done", 32'(DONE), 32'd0);
    LD_VALID = 1'b0;
    tick();
    tick();
    RST = 1'b0;
    tick();

    // Contents survive: full fetch still returns 0x0100+i
    fetch_run(31, 99, 99, -1);
    chk("post_c29_dat", 32'(r_dat[29]), 32'h011B);
    chk("post_c30_done", 32'(r_don[30]), 32'd1);
    tick();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
